wts_sram_access_controller: RTL and testbench



---
 rtl/wts_pkg.sv | 46 ++++
 rtl/wts_cmd_fifo.sv | 62 ++++++
 rtl/wts_sram_access_controller.sv | 193 +++++++++++++++++++
 tb/tb_wts_sram_access_controller.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wts_pkg.sv
// ============================================================================
// Module      : wts_pkg
// Description : Shared constants, address field positions, FSM state encoding
//               and the queued command format for the wave-table SRAM access
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wts_pkg;

  // Mixer rotation: slots 0..5, slot 5 services the wave-memory port.
  localparam logic [2:0] WTS_SERVICE_SLOT = 3'd5;
  localparam int         WTS_NUM_SLOTS    = 6;

  // Channels A..E map to ids 0..4; anything above is rejected.
  localparam logic [2:0] WTS_MAX_ID = 3'd4;

  // CPU address layout: [10]=bank, [9:7]=channel id, [6:0]=byte offset.
  localparam int WTS_BANK_BIT = 10;
  localparam int WTS_ID_MSB   = 9;
  localparam int WTS_ID_LSB   = 7;
  localparam int WTS_A_MSB    = 6;
  localparam int WTS_A_LSB    = 0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_SLOT = 3'd2,
    ST_WAIT_DATA = 3'd3,
    ST_GAP       = 3'd4
  } wts_state_t;

  typedef struct packed {
    logic       wr;
    logic       bank;
    logic [2:0] id;
    logic [6:0] a;
    logic [7:0] d;
  } wts_cmd_t;

  localparam int WTS_CMD_W = $bits(wts_cmd_t);

endpackage

`default_nettype wire

// File: rtl/wts_cmd_fifo.sv
// ============================================================================
// Module      : wts_cmd_fifo
// Description : Synchronous command FIFO with full/empty flags. Pointers carry
//               one extra wrap bit so full and empty are distinguishable.
// Ports       : clk, reset (async, active-high)
//               i_push/i_din  - write side, ignored while full
//               i_pop/o_dout  - read side, o_dout shows the head entry
//               o_full/o_empty - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wts_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int              c_AW      = $clog2(DEPTH);
  localparam logic [c_AW:0]   c_PTR_ONE = (c_AW+1)'(1);

  logic [c_AW:0]      r_wr_ptr;
  logic [c_AW:0]      r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_push_ok;
  logic               w_pop_ok;

  // Same index with different wrap bits means the writer lapped the reader.
  assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);

  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop  && !o_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[c_AW-1:0]] <= i_din;
  end

  assign o_dout = r_mem[r_rd_ptr[c_AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/wts_sram_access_controller.sv
// ============================================================================
// Module      : wts_sram_access_controller
// Description : CPU-side initiator for the wave-table mixer memory port.
//               Queues CPU byte reads/writes, issues one sram_oe/sram_we pulse
//               per command, waits for the mixer service slot (active==5) and
//               returns read data in request order.
// Ports       : clk, reset (async, active-high)
//               cpu_req/cpu_wr/cpu_address/cpu_wdata/cpu_ready - request side
//               cpu_rdata/cpu_rdata_en                         - read return
//               cpu_error/cpu_error_clr                        - sticky error
//               active                                         - mixer slot
//               sram_ce0/ce1/id/a/d/oe/we                      - mixer request
//               sram_q/sram_q_en                               - mixer read data
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wts_sram_access_controller
  import wts_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [10:0] cpu_address,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ready,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdata_en,
  output logic        cpu_error,
  input  logic        cpu_error_clr,
  input  logic [2:0]  active,
  output logic        sram_ce0,
  output logic        sram_ce1,
  output logic [2:0]  sram_id,
  output logic [6:0]  sram_a,
  output logic [7:0]  sram_d,
  output logic        sram_oe,
  output logic        sram_we,
  input  logic [7:0]  sram_q,
  input  logic        sram_q_en
);

  localparam int                 c_TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
  localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);

  wts_state_t              r_state;
  wts_state_t              w_state_nxt;
  wts_cmd_t                w_cmd_in;
  wts_cmd_t                w_head;
  logic [WTS_CMD_W-1:0]    w_fifo_dout;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_issue;
  logic                    w_bad;
  logic                    w_rd_done;
  logic                    w_rd_abort;
  logic                    r_cmd_wr;
  logic [c_TMO_W-1:0]      r_tmo_cnt;

  assign cpu_ready = !w_full;
  assign w_push    = cpu_req && cpu_ready;

  always_comb begin
    w_cmd_in      = '0;
    w_cmd_in.wr   = cpu_wr;
    w_cmd_in.bank = cpu_address[WTS_BANK_BIT];
    w_cmd_in.id   = cpu_address[WTS_ID_MSB:WTS_ID_LSB];
    w_cmd_in.a    = cpu_address[WTS_A_MSB:WTS_A_LSB];
    w_cmd_in.d    = cpu_wdata;
  end

  wts_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WTS_CMD_W)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (w_cmd_in),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head = wts_cmd_t'(w_fifo_dout);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
    w_bad       = 1'b0;
    w_rd_done   = 1'b0;
    w_rd_abort  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head.id > WTS_MAX_ID) begin
            w_bad       = 1'b1;
            w_state_nxt = ST_GAP;
          end else begin
            w_issue     = 1'b1;
            w_state_nxt = ST_ISSUE;
          end
        end
      end
      // The pulse registered on the IDLE->ISSUE edge is visible in this cycle.
      ST_ISSUE:     w_state_nxt = ST_WAIT_SLOT;
      // Entered only after the pulse cycle, so a pulse issued in slot 5 waits
      // a full rotation.
      ST_WAIT_SLOT: begin
        if (active == WTS_SERVICE_SLOT)
          w_state_nxt = r_cmd_wr ? ST_GAP : ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (sram_q_en) begin
          w_rd_done   = 1'b1;
          w_state_nxt = ST_GAP;
        end else if (r_tmo_cnt == c_TMO_LAST) begin
          w_rd_abort  = 1'b1;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP:       w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd_wr     <= 1'b0;
      r_tmo_cnt    <= '0;
      cpu_rdata    <= 8'h00;
      cpu_rdata_en <= 1'b0;
      cpu_error    <= 1'b0;
      sram_ce0     <= 1'b0;
      sram_ce1     <= 1'b0;
      sram_id      <= 3'd0;
      sram_a       <= 7'd0;
      sram_d       <= 8'h00;
      sram_oe      <= 1'b0;
      sram_we      <= 1'b0;
    end else begin
      sram_oe      <= 1'b0;
      sram_we      <= 1'b0;
      cpu_rdata_en <= 1'b0;

      if (r_state == ST_WAIT_DATA) r_tmo_cnt <= r_tmo_cnt + c_TMO_ONE;
      else                         r_tmo_cnt <= '0;

      if (w_pop) r_cmd_wr <= w_head.wr;

      // Address/data lines hold their values until the next pulse.
      if (w_issue) begin
        sram_ce0 <= !w_head.bank;
        sram_ce1 <= w_head.bank;
        sram_id  <= w_head.id;
        sram_a   <= w_head.a;
        sram_d   <= w_head.d;
        sram_we  <= w_head.wr;
        sram_oe  <= !w_head.wr;
      end

      if (w_rd_done) begin
        cpu_rdata    <= sram_q;
        cpu_rdata_en <= 1'b1;
      end else if (w_rd_abort || (w_bad && !w_head.wr)) begin
        cpu_rdata    <= 8'hFF;
        cpu_rdata_en <= 1'b1;
      end

      // Set wins over a simultaneous clear.
      if (w_bad || w_rd_abort) cpu_error <= 1'b1;
      else if (cpu_error_clr)  cpu_error <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wts_sram_access_controller.sv
// ============================================================================
// Module      : tb_wts_sram_access_controller
// Description : Self-checking bench with a mixer model and scoreboard queues
//               for expected sram pulses and expected read returns.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wts_sram_access_controller;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_wr;
  logic [10:0] cpu_address;
  logic [7:0]  cpu_wdata;
  logic        cpu_ready;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdata_en;
  logic        cpu_error;
  logic        cpu_error_clr;
  logic [2:0]  active;
  logic        sram_ce0;
  logic        sram_ce1;
  logic [2:0]  sram_id;
  logic [6:0]  sram_a;
  logic [7:0]  sram_d;
  logic        sram_oe;
  logic        sram_we;
  logic [7:0]  sram_q;
  logic        sram_q_en;

  wts_sram_access_controller #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_req       (cpu_req),
    .cpu_wr        (cpu_wr),
    .cpu_address   (cpu_address),
    .cpu_wdata     (cpu_wdata),
    .cpu_ready     (cpu_ready),
    .cpu_rdata     (cpu_rdata),
    .cpu_rdata_en  (cpu_rdata_en),
    .cpu_error     (cpu_error),
    .cpu_error_clr (cpu_error_clr),
    .active        (active),
    .sram_ce0      (sram_ce0),
    .sram_ce1      (sram_ce1),
    .sram_id       (sram_id),
    .sram_a        (sram_a),
    .sram_d        (sram_d),
    .sram_oe       (sram_oe),
    .sram_we       (sram_we),
    .sram_q        (sram_q),
    .sram_q_en     (sram_q_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] fields;  // {we, oe, ce0, ce1, id, a, d}
    int          cyc;     // expected pulse cycle, -1 = not timed
  } pulse_t;

  typedef struct {
    logic [7:0] data;
    int         cyc;      // expected cpu_rdata_en cycle, -1 = not timed
  } rd_t;

  pulse_t     pq[$];
  rd_t        rq[$];
  logic [7:0] mem    [2][8][128];
  logic [7:0] shadow [2][8][128];

  int vectors     = 0;
  int miscompares = 0;

  // Mixer model state
  int         cyc         = 0;
  int         rd_due      = -1;
  int         last_service = -100;
  int         n_services  = 0;
  bit         pending     = 1'b0;
  bit         suppress    = 1'b0;
  logic       p_we;
  logic       p_bank;
  logic [2:0] p_id;
  logic [6:0] p_a;
  logic [7:0] p_d;
  logic [7:0] q_val;

  function automatic int slot_dist(input int pc);
    int d = 1;
    while (((pc + d) % 6) != 5) d++;
    return d;
  endfunction

  // Mixer model and output monitor: runs just after every rising edge.
  always @(posedge clk) begin
    pulse_t e;
    rd_t    r;
    #1;
    cyc++;
    active    = 3'(cyc % 6);
    sram_q_en = 1'b0;
    if (reset) begin
      pending = 1'b0;
      rd_due  = -1;
    end else begin
      if (rd_due == cyc) begin
        sram_q_en = !suppress;
        sram_q    = q_val;
        rd_due    = -1;
      end
      if (pending && active == 3'd5) begin
        if (p_we) mem[p_bank][p_id][p_a] = p_d;
        else begin
          q_val  = mem[p_bank][p_id][p_a];
          rd_due = cyc + 1;
        end
        pending      = 1'b0;
        last_service = cyc;
        n_services++;
      end
      if (sram_we || sram_oe) begin
        vectors++;
        assert (!pending && cyc >= last_service + 2 && !(sram_we && sram_oe)) else begin
          miscompares++;
          $error("FAIL pulse_spacing cycle=%0d observed pending=%0b last_service=%0d we=%0b oe=%0b expected no overlap, >= service+2",
                 cyc, pending, last_service, sram_we, sram_oe);
        end
        vectors++;
        assert (pq.size() > 0) else begin
          miscompares++;
          $error("FAIL unexpected_pulse cycle=%0d observed a pulse expected none", cyc);
        end
        if (pq.size() > 0) begin
          e = pq.pop_front();
          vectors++;
          assert ({sram_we, sram_oe, sram_ce0, sram_ce1, sram_id, sram_a, sram_d} === e.fields) else begin
            miscompares++;
            $error("FAIL pulse_fields observed=%h expected=%h",
                   {sram_we, sram_oe, sram_ce0, sram_ce1, sram_id, sram_a, sram_d}, e.fields);
          end
          if (e.cyc >= 0) begin
            vectors++;
            assert (cyc === e.cyc) else begin
              miscompares++;
              $error("FAIL pulse_latency observed=%0d expected=%0d", cyc, e.cyc);
            end
          end
        end
        pending = 1'b1;
        p_we    = sram_we;
        p_bank  = sram_ce1;
        p_id    = sram_id;
        p_a     = sram_a;
        p_d     = sram_d;
      end
    end
    if (cpu_rdata_en) begin
      vectors++;
      assert (rq.size() > 0) else begin
        miscompares++;
        $error("FAIL unexpected_rdata_en cycle=%0d observed strobe expected none", cyc);
      end
      if (rq.size() > 0) begin
        r = rq.pop_front();
        vectors++;
        assert (cpu_rdata === r.data) else begin
          miscompares++;
          $error("FAIL rdata observed=%h expected=%h", cpu_rdata, r.data);
        end
        if (r.cyc >= 0) begin
          vectors++;
          assert (cyc === r.cyc) else begin
            miscompares++;
            $error("FAIL rdata_latency observed=%0d expected=%0d", cyc, r.cyc);
          end
        end
      end
    end
  end

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic send(input logic wr, input logic [10:0] addr, input logic [7:0] wd,
                      input bit timed, input bit tmo);
    int     w = 0;
    int     pc;
    pulse_t p;
    rd_t    r;
    while (!cpu_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    vectors++;
    assert (cpu_ready === 1'b1) else begin
      miscompares++;
      $error("FAIL ready_wait observed=%0b expected=1", cpu_ready);
    end
    cpu_req     = 1'b1;
    cpu_wr      = wr;
    cpu_address = addr;
    cpu_wdata   = wd;
    pc = timed ? cyc + 2 : -1;
    if (addr[9:7] <= 3'd4) begin
      p.fields = {wr, !wr, !addr[10], addr[10], addr[9:7], addr[6:0], wd};
      p.cyc    = pc;
      pq.push_back(p);
      if (wr) shadow[addr[10]][addr[9:7]][addr[6:0]] = wd;
      else begin
        r.data = tmo ? 8'hFF : shadow[addr[10]][addr[9:7]][addr[6:0]];
        r.cyc  = timed ? pc + slot_dist(pc) + (tmo ? TIMEOUT + 1 : 2) : -1;
        rq.push_back(r);
      end
    end else if (!wr) begin
      r.data = 8'hFF;
      r.cyc  = -1;
      rq.push_back(r);
    end
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((pq.size() != 0 || rq.size() != 0) && w < 300) begin
      @(negedge clk);
      w++;
    end
    vectors++;
    assert (pq.size() == 0 && rq.size() == 0) else begin
      miscompares++;
      $error("FAIL drain observed pulses=%0d reads=%0d outstanding expected 0", pq.size(), rq.size());
    end
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int w;
    int n0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 8; i++)
        for (int a = 0; a < 128; a++) begin
          mem[b][i][a]    = 8'h00;
          shadow[b][i][a] = 8'h00;
        end
    reset         = 1'b1;
    cpu_req       = 1'b0;
    cpu_wr        = 1'b0;
    cpu_address   = 11'h000;
    cpu_wdata     = 8'h00;
    cpu_error_clr = 1'b0;
    active        = 3'd0;
    sram_q        = 8'h00;
    sram_q_en     = 1'b0;
    repeat (3) @(negedge clk);

    vectors++;
    assert ({cpu_rdata, cpu_rdata_en, cpu_error, sram_ce0, sram_ce1, sram_id, sram_a, sram_d, sram_oe, sram_we} === 33'd0) else begin
      miscompares++;
      $error("FAIL reset_outputs observed=%h expected=0",
             {cpu_rdata, cpu_rdata_en, cpu_error, sram_ce0, sram_ce1, sram_id, sram_a, sram_d, sram_oe, sram_we});
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    assert (cpu_ready === 1'b1) else begin
      miscompares++;
      $error("FAIL reset_ready observed=%0b expected=1", cpu_ready);
    end
    repeat (2) @(negedge clk);

    // Write then read back through the mixer.
    send(1'b1, 11'h085, 8'h5A, 1'b1, 1'b0);
    drain();
    send(1'b0, 11'h085, 8'h00, 1'b1, 1'b0);
    drain();

    // Pulse landing in the service slot waits a full rotation.
    while ((cyc % 6) != 3) @(negedge clk);
    send(1'b0, 11'h085, 8'h00, 1'b1, 1'b0);
    send(1'b1, 11'h4FF, 8'hA7, 1'b0, 1'b0);
    send(1'b0, 11'h4FF, 8'h00, 1'b0, 1'b0);
    drain();

    // Back-to-back with the FSM busy on a read: queue fills after 4.
    send(1'b0, 11'h085, 8'h00, 1'b1, 1'b0);
    send(1'b1, 11'h201, 8'h11, 1'b0, 1'b0);
    send(1'b1, 11'h602, 8'h22, 1'b0, 1'b0);
    send(1'b0, 11'h201, 8'h00, 1'b0, 1'b0);
    send(1'b0, 11'h602, 8'h00, 1'b0, 1'b0);
    vectors++;
    assert (cpu_ready === 1'b0) else begin
      miscompares++;
      $error("FAIL queue_full_ready observed=%0b expected=0", cpu_ready);
    end
    send(1'b1, 11'h201, 8'h33, 1'b0, 1'b0);
    send(1'b0, 11'h201, 8'h00, 1'b0, 1'b0);
    drain();

    // Invalid id read: no pulse, 0xFF, sticky error, then clear.
    send(1'b0, 11'h780, 8'h00, 1'b0, 1'b0);
    drain();
    vectors++;
    assert (cpu_error === 1'b1) else begin
      miscompares++;
      $error("FAIL bad_id_error observed=%0b expected=1", cpu_error);
    end
    cpu_error_clr = 1'b1;
    @(negedge clk);
    cpu_error_clr = 1'b0;
    vectors++;
    assert (cpu_error === 1'b0) else begin
      miscompares++;
      $error("FAIL error_clear observed=%0b expected=0", cpu_error);
    end

    // Read timeout, then the queue resumes.
    suppress = 1'b1;
    send(1'b0, 11'h085, 8'h00, 1'b1, 1'b1);
    drain();
    vectors++;
    assert (cpu_error === 1'b1) else begin
      miscompares++;
      $error("FAIL timeout_error observed=%0b expected=1", cpu_error);
    end
    suppress      = 1'b0;
    cpu_error_clr = 1'b1;
    @(negedge clk);
    cpu_error_clr = 1'b0;
    send(1'b1, 11'h10A, 8'hC3, 1'b1, 1'b0);
    send(1'b0, 11'h10A, 8'h00, 1'b0, 1'b0);
    drain();

    // Reset while waiting for read data with two entries still queued.
    suppress = 1'b1;
    n0 = n_services;
    send(1'b0, 11'h085, 8'h00, 1'b0, 1'b0);
    send(1'b0, 11'h201, 8'h00, 1'b0, 1'b0);
    send(1'b0, 11'h602, 8'h00, 1'b0, 1'b0);
    w = 0;
    while (n_services == n0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    vectors++;
    assert (n_services != n0) else begin
      miscompares++;
      $error("FAIL reset_setup observed services=%0d expected >%0d", n_services, n0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pq.delete();
    rq.delete();
    #2;
    vectors++;
    assert ({cpu_rdata, cpu_rdata_en, cpu_error, sram_ce0, sram_ce1, sram_id, sram_a, sram_d, sram_oe, sram_we} === 33'd0) else begin
      miscompares++;
      $error("FAIL midop_reset_outputs observed=%h expected=0",
             {cpu_rdata, cpu_rdata_en, cpu_error, sram_ce0, sram_ce1, sram_id, sram_a, sram_d, sram_oe, sram_we});
    end
    repeat (3) @(negedge clk);
    reset    = 1'b0;
    suppress = 1'b0;
    @(negedge clk);
    vectors++;
    assert (cpu_ready === 1'b1) else begin
      miscompares++;
      $error("FAIL midop_reset_ready observed=%0b expected=1", cpu_ready);
    end
    repeat (30) @(negedge clk);

    // Normal operation after reset.
    send(1'b1, 11'h57F, 8'h96, 1'b1, 1'b0);
    send(1'b0, 11'h57F, 8'h00, 1'b0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
